pi_controller_mc: RTL

Parametrised, multi-channel successor to the single-channel velocity PI controller for the BLDC velocity loop. It time-multiplexes one multiplier across CHANNELS motor channels, computing one PI update per channel on each `start` pulse. Error, integrator, products and output all saturate instead of wrapping, and the integrator uses conditional-integration anti-windup. It sits between the velocity estimators and the PWM duty-cycle generators.

---
 rtl/pi_controller_mc_pkg.sv | 35 +++
 rtl/pi_controller_mc_if.sv | 41 ++++
 rtl/pi_controller_mc_signed_saturate.sv | 25 ++
 rtl/pi_controller_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pi_controller_mc_pkg.sv
// -----------------------------------------------------------------------------
// pi_ctrl_pkg
// Shared types and helpers for the multi-channel PI velocity controller.
//   state_t        : sequencer states, one update per channel takes
//                    STATES_PER_CH cycles (ERR, INTEG, MUL_P, MUL_I, SUM).
//   STATES_PER_CH  : cycles spent per channel.
//   sat_resize     : clamps a signed value to the signed range of a given width.
// -----------------------------------------------------------------------------
package pi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_INTEG,
    ST_MUL_P,
    ST_MUL_I,
    ST_SUM
  } state_t;

  localparam int STATES_PER_CH = 5;

  // Clamp v into [-2^(w-1), 2^(w-1)-1]; result is still 64 bits wide so the
  // caller can truncate to w bits without losing information.
  function automatic logic signed [63:0] sat_resize(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pi_controller_mc_if.sv
// -----------------------------------------------------------------------------
// pi_controller_mc_if
// Request/response bundle between the velocity estimators / PWM generators and
// the PI controller.
//   start, integ_clear : requests from the system (master drives)
//   desired, actual    : packed per-channel signed velocities, channel c at
//                        [c*IN_W +: IN_W]
//   kp, ki             : shared signed gains
//   busy, done         : sequencer status (controller drives)
//   output_gain        : packed per-channel signed duty gains, [c*OUT_W +: OUT_W]
//   saturated          : per-channel output clamp flags
// -----------------------------------------------------------------------------
interface pi_controller_mc_if #(
  parameter int CHANNELS = 3,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 16,
  parameter int OUT_W    = 12
);

  logic                       start;
  logic                       integ_clear;
  logic [CHANNELS*IN_W-1:0]   desired;
  logic [CHANNELS*IN_W-1:0]   actual;
  logic signed [GAIN_W-1:0]   kp;
  logic signed [GAIN_W-1:0]   ki;
  logic                       busy;
  logic                       done;
  logic [CHANNELS*OUT_W-1:0]  output_gain;
  logic [CHANNELS-1:0]        saturated;

  modport master (
    output start, integ_clear, desired, actual, kp, ki,
    input  busy, done, output_gain, saturated
  );

  modport slave (
    input  start, integ_clear, desired, actual, kp, ki,
    output busy, done, output_gain, saturated
  );

endinterface

// File: rtl/pi_controller_mc_signed_saturate.sv
// -----------------------------------------------------------------------------
// signed_saturate
// Combinational clamp of a signed IN_WIDTH value into the signed OUT_WIDTH
// range (no wrap-around).
//   din  : signed input, IN_WIDTH bits
//   dout : clamped signed output, OUT_WIDTH bits
// -----------------------------------------------------------------------------
module signed_saturate
  import pi_ctrl_pkg::*;
#(
  parameter int IN_WIDTH  = 17,
  parameter int OUT_WIDTH = 16
) (
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout
);

  logic signed [63:0] wide;
  logic signed [63:0] clamped;

  assign wide    = 64'(din);
  assign clamped = sat_resize(wide, OUT_WIDTH);
  assign dout    = OUT_WIDTH'(clamped);

endmodule

// File: rtl/pi_controller_mc.sv
// -----------------------------------------------------------------------------
// pi_controller_mc
// Multi-channel saturating PI velocity controller. One multiplier is shared by
// all channels; each start pulse runs ERR -> INTEG -> MUL_P -> MUL_I -> SUM for
// channel 0, 1, ... CHANNELS-1, then pulses done.
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : pi_controller_mc_if slave (start, integ_clear, desired, actual,
//           kp, ki in; busy, done, output_gain, saturated out)
// -----------------------------------------------------------------------------
module pi_controller_mc
  import pi_ctrl_pkg::*;
#(
  parameter int CHANNELS  = 3,
  parameter int IN_W      = 16,
  parameter int GAIN_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_W     = 12
) (
  input  logic             clk,
  input  logic             reset,
  pi_controller_mc_if.slave bus
);

  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = GAIN_W + IN_W;
  localparam int MUL_W  = GAIN_W + ACC_W;
  localparam int SUM_W  = MUL_W + 1;

  state_t state, state_nxt;
  logic [CH_W-1:0] ch;
  logic            last_ch;

  logic load, clr, err_en, integ_en, mul_p_en, mul_i_en, sum_en;

  logic signed [IN_W-1:0]   des_l [CHANNELS];
  logic signed [IN_W-1:0]   act_l [CHANNELS];
  logic signed [GAIN_W-1:0] kp_l, ki_l;

  logic signed [ACC_W-1:0]  acc   [CHANNELS];
  logic signed [OUT_W-1:0]  out_r [CHANNELS];
  logic [CHANNELS-1:0]      sat_r;
  logic                     done_r;

  logic signed [IN_W:0]     diff;
  logic signed [IN_W-1:0]   err_c, err_p0;
  logic signed [ACC_W:0]    acc_sum;
  logic signed [ACC_W-1:0]  acc_c;
  logic                     hold;

  logic signed [GAIN_W-1:0] mul_a;
  logic signed [ACC_W-1:0]  mul_b;
  logic signed [MUL_W-1:0]  mul_y;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [MUL_W-1:0]  prod2_p2;

  logic signed [SUM_W-1:0]  sum, sum_sh;
  logic signed [OUT_W-1:0]  out_c;
  logic                     out_sat;

  assign last_ch = (ch == CH_W'(CHANNELS - 1));

  // ---------------------------------------------------------------------------
  // Sequencer: state register, next-state logic, decoded stage enables
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.start) state_nxt = ST_ERR;
      ST_ERR:   state_nxt = ST_INTEG;
      ST_INTEG: state_nxt = ST_MUL_P;
      ST_MUL_P: state_nxt = ST_MUL_I;
      ST_MUL_I: state_nxt = ST_SUM;
      ST_SUM:   state_nxt = last_ch ? ST_IDLE : ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    clr      = 1'b0;
    err_en   = 1'b0;
    integ_en = 1'b0;
    mul_p_en = 1'b0;
    mul_i_en = 1'b0;
    sum_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        load = bus.start;
        clr  = bus.integ_clear;
      end
      ST_ERR:   err_en   = 1'b1;
      ST_INTEG: integ_en = 1'b1;
      ST_MUL_P: mul_p_en = 1'b1;
      ST_MUL_I: mul_i_en = 1'b1;
      ST_SUM:   sum_en   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch     <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= sum_en && last_ch;
      if (load)                  ch <= '0;
      else if (sum_en && !last_ch) ch <= ch + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Input snapshot taken on an accepted start
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load) begin
      for (int c = 0; c < CHANNELS; c++) begin
        des_l[c] <= $signed(bus.desired[c*IN_W +: IN_W]);
        act_l[c] <= $signed(bus.actual[c*IN_W +: IN_W]);
      end
      kp_l <= bus.kp;
      ki_l <= bus.ki;
    end
  end

  // ---------------------------------------------------------------------------
  // ERR stage: one extra bit so the subtraction cannot wrap before clamping
  // ---------------------------------------------------------------------------
  assign diff = (IN_W+1)'(des_l[ch]) - (IN_W+1)'(act_l[ch]);

  signed_saturate #(.IN_WIDTH(IN_W + 1), .OUT_WIDTH(IN_W)) u_err_sat (
    .din  (diff),
    .dout (err_c)
  );

  always_ff @(posedge clk) begin
    if (err_en) err_p0 <= err_c;
  end

  // ---------------------------------------------------------------------------
  // INTEG stage: conditional integration. While the output sits on a rail,
  // an error pushing further into that rail is not accumulated.
  // ---------------------------------------------------------------------------
  assign acc_sum = (ACC_W+1)'(acc[ch]) + (ACC_W+1)'(err_p0);
  assign hold    = sat_r[ch] && (err_p0[IN_W-1] == out_r[ch][OUT_W-1]);

  signed_saturate #(.IN_WIDTH(ACC_W + 1), .OUT_WIDTH(ACC_W)) u_acc_sat (
    .din  (acc_sum),
    .dout (acc_c)
  );

  // Clear is only decoded in IDLE, so it lands before the first INTEG of a
  // sequence started in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else if (clr) begin
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
    end else if (integ_en && !hold) begin
      acc[ch] <= acc_c;
    end
  end

  // ---------------------------------------------------------------------------
  // MUL_P / MUL_I stages: single shared multiplier, operands muxed by stage
  // ---------------------------------------------------------------------------
  assign mul_a = mul_i_en ? ki_l : kp_l;
  assign mul_b = mul_i_en ? acc[ch] : ACC_W'(err_p0);
  assign mul_y = MUL_W'(mul_a) * MUL_W'(mul_b);

  // kp*err always fits PROD_W, so the low slice is exact.
  always_ff @(posedge clk) begin
    if (mul_p_en) prod_p1  <= mul_y[PROD_W-1:0];
    if (mul_i_en) prod2_p2 <= mul_y;
  end

  // ---------------------------------------------------------------------------
  // SUM stage: widened add, floor shift out of Q format, clamp to OUT_W
  // ---------------------------------------------------------------------------
  assign sum    = SUM_W'(prod_p1) + SUM_W'(prod2_p2);
  assign sum_sh = sum >>> FRAC_BITS;

  signed_saturate #(.IN_WIDTH(SUM_W), .OUT_WIDTH(OUT_W)) u_out_sat (
    .din  (sum_sh),
    .dout (out_c)
  );

  assign out_sat = (sum_sh != SUM_W'(out_c));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) out_r[c] <= '0;
      sat_r <= '0;
    end else if (sum_en) begin
      out_r[ch] <= out_c;
      sat_r[ch] <= out_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_r;
  assign bus.saturated = sat_r;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign bus.output_gain[g*OUT_W +: OUT_W] = out_r[g];
  end

endmodule
